// File: rtl/pulse_monitor_pkg.sv
// Shared types and default constants for the pulse monitor.
package pulse_monitor_pkg;

  typedef enum logic [1:0] {
    SWAIT = 2'd0,
    SMEAS = 2'd1,
    SLOCK = 2'd2,
    SLOST = 2'd3
  } pm_state_e;

  localparam int CNT_W_DEF   = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int LOCK_N_DEF  = 3;
  localparam int MATCH_W     = 4;

endpackage

// File: rtl/pulse_edge_det.sv
// Rising-edge detector: one history flop, combinational rise flag.
module pulse_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pulse_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= 1'b0;
    end else begin
      hist_q <= pulse_i;
    end
  end

  assign rise_o = pulse_i & ~hist_q;

endmodule

// File: rtl/pulse_monitor.sv
// Pulse-train monitor: edge count, period measurement, lock and loss-of-pulse detection.
// Define PULSE_MONITOR_HIST_EN to add the MIN_PERIOD/MAX_PERIOD history outputs.
module pulse_monitor
  import pulse_monitor_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int LOCK_N  = LOCK_N_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PULSE,
  input  logic             CLR,
  output logic             EDGE,
  output logic [CNT_W-1:0] COUNT,
  output logic [CNT_W-1:0] PERIOD,
  output logic             LOCKED,
`ifdef PULSE_MONITOR_HIST_EN
  output logic [CNT_W-1:0] MIN_PERIOD,
  output logic [CNT_W-1:0] MAX_PERIOD,
`endif
  output logic             TIMEOUT_FLAG
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   TO_GAP    = CNT_W'(TIMEOUT - 1);
  localparam logic [MATCH_W-1:0] MATCH_MAX = '1;
  localparam logic [MATCH_W-1:0] LOCK_CNT  = MATCH_W'(LOCK_N);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic               rise;
  pm_state_e          state_q, state_d;
  logic [CNT_W-1:0]   gap_q, gap_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic               tflag_q, tflag_d;
  logic               edge_q, edge_d;
  logic               locked_q, locked_d;
  logic [CNT_W-1:0]   meas;
  logic [MATCH_W-1:0] match_inc;
`ifdef PULSE_MONITOR_HIST_EN
  logic [CNT_W-1:0]   min_q, min_d;
  logic [CNT_W-1:0]   max_q, max_d;
`endif

  pulse_edge_det u_edge_det (
    .clk_i   (CLK),
    .rst_i   (RST),
    .pulse_i (PULSE),
    .rise_o  (rise)
  );

  // Interval since the previous rise, counting the rise cycle itself.
  assign meas      = sat_inc(gap_q);
  assign match_inc = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= SWAIT;
      gap_q    <= '0;
      count_q  <= '0;
      period_q <= '0;
      match_q  <= '0;
      tflag_q  <= 1'b0;
      edge_q   <= 1'b0;
      locked_q <= 1'b0;
`ifdef PULSE_MONITOR_HIST_EN
      min_q    <= '1;
      max_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      count_q  <= count_d;
      period_q <= period_d;
      match_q  <= match_d;
      tflag_q  <= tflag_d;
      edge_q   <= edge_d;
      locked_q <= locked_d;
`ifdef PULSE_MONITOR_HIST_EN
      min_q    <= min_d;
      max_q    <= max_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = sat_inc(gap_q);
    count_d  = count_q;
    period_d = period_q;
    match_d  = match_q;
    tflag_d  = tflag_q;
    edge_d   = 1'b0;
`ifdef PULSE_MONITOR_HIST_EN
    min_d    = min_q;
    max_d    = max_q;
`endif
    if (CLR) begin
      // Clear wins over a coincident rise; that rise is dropped entirely.
      state_d  = SWAIT;
      gap_d    = '0;
      count_d  = '0;
      period_d = '0;
      match_d  = '0;
      tflag_d  = 1'b0;
`ifdef PULSE_MONITOR_HIST_EN
      min_d    = '1;
      max_d    = '0;
`endif
    end else if (rise) begin
      edge_d  = 1'b1;
      gap_d   = '0;
      count_d = count_q + 1'b1;
      case (state_q)
        SWAIT, SLOST: begin
          match_d = '0;
          state_d = SMEAS;
        end
        SMEAS, SLOCK: begin
          period_d = meas;
`ifdef PULSE_MONITOR_HIST_EN
          if (meas < min_q) min_d = meas;
          if (meas > max_q) max_d = meas;
`endif
          if ((meas == period_q) && (period_q != '0)) begin
            match_d = match_inc;
            if ((state_q == SMEAS) && (match_inc >= LOCK_CNT)) state_d = SLOCK;
          end else begin
            match_d = '0;
            state_d = SMEAS;
          end
        end
        default: state_d = SWAIT;
      endcase
    end else if (((state_q == SMEAS) || (state_q == SLOCK)) && (gap_q == TO_GAP)) begin
      state_d = SLOST;
      tflag_d = 1'b1;
    end
    locked_d = (state_d == SLOCK);
  end

  assign EDGE         = edge_q;
  assign COUNT        = count_q;
  assign PERIOD       = period_q;
  assign LOCKED       = locked_q;
  assign TIMEOUT_FLAG = tflag_q;
`ifdef PULSE_MONITOR_HIST_EN
  assign MIN_PERIOD   = min_q;
  assign MAX_PERIOD   = max_q;
`endif

endmodule

// File: tb/tb_pulse_monitor.sv
// Bench for pulse_monitor: two instances (TIMEOUT 16 and 255) on shared stimulus, checked against an event-time model.
module tb_pulse_monitor;

  localparam int LN = 3;

  logic CLK = 1'b0;
  logic RST;
  logic PULSE;
  logic CLR;

  logic [1:0]      edge_w;
  logic [1:0][7:0] count_w;
  logic [1:0][7:0] period_w;
  logic [1:0]      locked_w;
  logic [1:0]      tflag_w;
`ifdef PULSE_MONITOR_HIST_EN
  logic [1:0][7:0] min_w;
  logic [1:0][7:0] max_w;
`endif

  int checks = 0;
  int errors = 0;

  // Model state per instance, expressed in absolute cycle numbers.
  int tmo       [2] = '{16, 255};
  int m_count   [2];
  int m_period  [2];
  int m_matches [2];
  int m_active  [2];
  int m_locked  [2];
  int m_tflag   [2];
  int m_edge    [2];
  int m_last    [2];
  int m_min     [2];
  int m_max     [2];
  bit m_prev;
  int cyc;

  always #5 CLK = ~CLK;

  pulse_monitor #(.CNT_W(8), .TIMEOUT(16), .LOCK_N(LN)) u0 (
    .CLK(CLK), .RST(RST), .PULSE(PULSE), .CLR(CLR),
    .EDGE(edge_w[0]), .COUNT(count_w[0]), .PERIOD(period_w[0]), .LOCKED(locked_w[0]),
`ifdef PULSE_MONITOR_HIST_EN
    .MIN_PERIOD(min_w[0]), .MAX_PERIOD(max_w[0]),
`endif
    .TIMEOUT_FLAG(tflag_w[0])
  );

  pulse_monitor #(.CNT_W(8), .TIMEOUT(255), .LOCK_N(LN)) u1 (
    .CLK(CLK), .RST(RST), .PULSE(PULSE), .CLR(CLR),
    .EDGE(edge_w[1]), .COUNT(count_w[1]), .PERIOD(period_w[1]), .LOCKED(locked_w[1]),
`ifdef PULSE_MONITOR_HIST_EN
    .MIN_PERIOD(min_w[1]), .MAX_PERIOD(max_w[1]),
`endif
    .TIMEOUT_FLAG(tflag_w[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input int d);
    m_count[d]   = 0;
    m_period[d]  = 0;
    m_matches[d] = 0;
    m_active[d]  = 0;
    m_locked[d]  = 0;
    m_tflag[d]   = 0;
    m_edge[d]    = 0;
    m_min[d]     = 255;
    m_max[d]     = 0;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      model_clear(d);
      m_last[d] = 0;
    end
    m_prev = 1'b0;
    cyc    = 0;
  endtask

  task automatic model_step(input logic p, input logic c);
    bit rise;
    int meas;
    rise   = p && !m_prev;
    m_prev = p;
    for (int d = 0; d < 2; d++) begin
      if (c) begin
        model_clear(d);
      end else if (rise) begin
        m_edge[d]  = 1;
        m_count[d] = (m_count[d] + 1) % 256;
        if (m_active[d] == 0) begin
          m_active[d]  = 1;
          m_matches[d] = 0;
          m_locked[d]  = 0;
        end else begin
          meas = cyc - m_last[d];
          if (meas > 255) meas = 255;
          if (meas == m_period[d] && m_period[d] != 0) begin
            m_matches[d]++;
          end else begin
            m_matches[d] = 0;
            m_locked[d]  = 0;
          end
          m_period[d] = meas;
          if (meas < m_min[d]) m_min[d] = meas;
          if (meas > m_max[d]) m_max[d] = meas;
          if (m_matches[d] >= LN) m_locked[d] = 1;
        end
        m_last[d] = cyc;
      end else begin
        m_edge[d] = 0;
        if (m_active[d] != 0 && (cyc - m_last[d]) >= tmo[d]) begin
          m_active[d] = 0;
          m_locked[d] = 0;
          m_tflag[d]  = 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_all(input string where);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s.u%0d.edge", where, d),   32'(edge_w[d]),   m_edge[d]);
      chk($sformatf("%s.u%0d.count", where, d),  32'(count_w[d]),  m_count[d]);
      chk($sformatf("%s.u%0d.period", where, d), 32'(period_w[d]), m_period[d]);
      chk($sformatf("%s.u%0d.locked", where, d), 32'(locked_w[d]), m_locked[d]);
      chk($sformatf("%s.u%0d.tflag", where, d),  32'(tflag_w[d]),  m_tflag[d]);
`ifdef PULSE_MONITOR_HIST_EN
      chk($sformatf("%s.u%0d.min", where, d),    32'(min_w[d]),    m_min[d]);
      chk($sformatf("%s.u%0d.max", where, d),    32'(max_w[d]),    m_max[d]);
`endif
    end
  endtask

  // Called just after a rising edge; applies inputs for the next cycle.
  task automatic step(input logic p, input logic c);
    PULSE = p;
    CLR   = c;
    @(posedge CLK);
    model_step(p, c);
    #1;
    check_all("step");
  endtask

  initial begin
    int sp;
    int hi;
    RST   = 1'b1;
    PULSE = 1'b0;
    CLR   = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_all("reset");
    chk("reset.count", 32'(count_w[0]), 0);
    RST = 1'b0;

    // Alternating 1/0: period 2 on the 2nd rise, lock on the 5th.
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b0);
      if (i == 2) chk("alt.period2", 32'(period_w[0]), 2);
      if (i == 5) begin
        chk("alt.locked5", 32'(locked_w[0]), 1);
        chk("alt.count5", 32'(count_w[0]), 5);
      end
      step(1'b0, 1'b0);
    end

    // One period of 3 breaks lock; three more periods of 3 relock.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("p3.unlock", 32'(locked_w[0]), 0);
    chk("p3.period", 32'(period_w[0]), 3);
    for (int j = 1; j <= 3; j++) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    chk("p3.relock", 32'(locked_w[0]), 1);

    // Drop back to SMEAS, then starve the input for 16 cycles.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("to.smeas", 32'(locked_w[0]), 0);
    repeat (15) step(1'b0, 1'b0);
    chk("to.before", 32'(tflag_w[0]), 0);
    step(1'b0, 1'b0);
    chk("to.flag", 32'(tflag_w[0]), 1);
    chk("to.long_tmo_quiet", 32'(tflag_w[1]), 0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("to.sticky", 32'(tflag_w[0]), 1);
    chk("to.period_kept", 32'(period_w[0]), 2);
    chk("to.edge", 32'(edge_w[0]), 1);

    // Clear coinciding with a rise.
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("clr.edge", 32'(edge_w[0]), 0);
    chk("clr.count", 32'(count_w[0]), 0);
    chk("clr.period", 32'(period_w[0]), 0);
    chk("clr.tflag", 32'(tflag_w[0]), 0);
    chk("clr.locked", 32'(locked_w[0]), 0);
    step(1'b0, 1'b0);
    chk("clr.no_late_edge", 32'(edge_w[0]), 0);

    // Long idle in SWAIT never times out.
    repeat (300) step(1'b0, 1'b0);
    chk("wait.no_tmo0", 32'(tflag_w[0]), 0);
    chk("wait.no_tmo1", 32'(tflag_w[1]), 0);

    // COUNT wraps after 256 rises.
    step(1'b0, 1'b1);
    for (int i = 1; i <= 256; i++) begin
      step(1'b1, 1'b0);
      if (i == 255) chk("wrap.255", 32'(count_w[0]), 255);
      if (i == 256) chk("wrap.0", 32'(count_w[0]), 0);
      step(1'b0, 1'b0);
    end

    // Rise exactly at gap TIMEOUT-1 on the 255 instance: period 255, no timeout.
    repeat (253) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("sat.period", 32'(period_w[1]), 255);
    chk("sat.no_tmo", 32'(tflag_w[1]), 0);
    chk("sat.u0_tmo", 32'(tflag_w[0]), 1);

    // Randomized trains with occasional long gaps and clears.
    repeat (60) begin
      sp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 30)) : int'($urandom_range(2, 4));
      hi = int'($urandom_range(1, sp - 1));
      for (int k = 0; k < sp; k++)
        step((k < hi) ? 1'b1 : 1'b0, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
    end

    // Periods 2, 4, 3 after a clear.
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
`ifdef PULSE_MONITOR_HIST_EN
    chk("hist.min", 32'(min_w[0]), 2);
    chk("hist.max", 32'(max_w[0]), 4);
`endif
    chk("hist.period", 32'(period_w[0]), 3);

    // Asynchronous reset mid-train, between clock edges.
    PULSE = 1'b1;
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.count", 32'(count_w[0]), 0);
    repeat (2) @(posedge CLK);
    #1;
    check_all("arst.hold");
    RST = 1'b0;
    repeat (40) step(($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
